// File: rtl/fc_pkg.sv
// Shared widths and sequencer state encoding for the fully connected layer.
package fc_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT_RES,
        EMIT,
        DONE
    } fc_state_t;
endpackage

// File: rtl/fc_layer_scheduler_dot.sv
// Two-stage signed dot product: registered multiply, then a framed accumulate.
// The result appears two cycles after the eop element is presented.
module vector_dot_product
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic                     sop,
    input  logic                     eop,
    input  logic signed [DATA_W-1:0] data_a,
    input  logic signed [DATA_W-1:0] data_b,
    output logic                     result_valid,
    output logic signed [ACC_W-1:0]  result
);
    localparam int PROD_W = 2 * DATA_W;

    logic                     p_vld_q, p_sop_q, p_eop_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     res_vld_q;
    logic signed [ACC_W-1:0]  res_q;

    // sop restarts the sum so no explicit clear cycle is needed between rows
    always_comb acc_d = (p_sop_q ? '0 : acc_q) + ACC_W'(prod_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld_q   <= 1'b0;
            p_sop_q   <= 1'b0;
            p_eop_q   <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            p_vld_q   <= valid_in;
            res_vld_q <= p_vld_q && p_eop_q;
            if (valid_in) begin
                prod_q  <= data_a * data_b;
                p_sop_q <= sop;
                p_eop_q <= eop;
            end
            if (p_vld_q) acc_q <= acc_d;
            if (p_vld_q && p_eop_q) res_q <= acc_d;
        end
    end

    assign result_valid = res_vld_q;
    assign result       = res_q;
endmodule

// File: rtl/fc_layer_scheduler.sv
// Fully connected layer sequencer: streams activations and weight rows into the
// dot product, adds bias, optionally applies ReLU and emits one result per neuron.
module fc_layer_scheduler
    import fc_pkg::*;
#(
    parameter int  IN_LEN  = 784,
    parameter int  OUT_LEN = 10,
    parameter bit  RELU    = 1'b1,
    localparam int X_AW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
    localparam int W_AW = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
    localparam int O_AW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [X_AW-1:0]          x_addr,
    input  logic signed [DATA_W-1:0] x_data,
    output logic [W_AW-1:0]          w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [O_AW-1:0]          b_addr,
    input  logic signed [ACC_W-1:0]  b_data,
    output logic                     y_valid,
    output logic [O_AW-1:0]          y_idx,
    output logic signed [ACC_W-1:0]  y_data
);
    fc_state_t               state_q, state_d;
    logic [O_AW-1:0]         n_q, n_d, b_addr_q, b_addr_d;
    logic [X_AW-1:0]         k_q, k_d;
    logic [W_AW-1:0]         w_addr_q, w_addr_d;
    logic                    k_last, n_last, sum_en, in_stream;
    logic                    dp_valid_q, dp_sop_q, dp_eop_q, bias_cap_q;
    logic signed [ACC_W-1:0] bias_q, sum_q;
    logic signed [DATA_W-1:0] dp_a, dp_b;
    logic                    dp_res_valid;
    logic signed [ACC_W-1:0] dp_result;

    assign k_last    = (k_q == X_AW'(IN_LEN - 1));
    assign n_last    = (n_q == O_AW'(OUT_LEN - 1));
    assign in_stream = (state_q == STREAM);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        w_addr_d = w_addr_q;
        b_addr_d = b_addr_q;
        sum_en   = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                n_d      = '0;
                k_d      = '0;
                w_addr_d = '0;
                b_addr_d = '0;
                state_d  = STREAM;
            end
            STREAM: if (k_last) begin
                state_d = WAIT_RES;
            end else begin
                k_d      = k_q + 1'b1;
                w_addr_d = w_addr_q + 1'b1;
            end
            WAIT_RES: if (dp_res_valid) begin
                sum_en  = 1'b1;
                state_d = EMIT;
            end
            // weight address is row-major, so the next row starts one past the last
            EMIT: if (n_last) begin
                state_d = DONE;
            end else begin
                n_d      = n_q + 1'b1;
                b_addr_d = n_q + 1'b1;
                k_d      = '0;
                w_addr_d = w_addr_q + 1'b1;
                state_d  = STREAM;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            k_q        <= '0;
            w_addr_q   <= '0;
            b_addr_q   <= '0;
            dp_valid_q <= 1'b0;
            dp_sop_q   <= 1'b0;
            dp_eop_q   <= 1'b0;
            bias_cap_q <= 1'b0;
            bias_q     <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            w_addr_q   <= w_addr_d;
            b_addr_q   <= b_addr_d;
            // memory read data lags the address by one cycle; framing follows it
            dp_valid_q <= in_stream;
            dp_sop_q   <= in_stream && (k_q == '0);
            dp_eop_q   <= in_stream && k_last;
            bias_cap_q <= in_stream && (k_q == '0);
            if (bias_cap_q) bias_q <= b_data;
            if (sum_en)     sum_q  <= dp_result + bias_q;
        end
    end

    assign dp_a = dp_valid_q ? x_data : '0;
    assign dp_b = dp_valid_q ? w_data : '0;

    vector_dot_product u_dot (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (dp_valid_q),
        .sop          (dp_sop_q),
        .eop          (dp_eop_q),
        .data_a       (dp_a),
        .data_b       (dp_b),
        .result_valid (dp_res_valid),
        .result       (dp_result)
    );

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign x_addr  = k_q;
    assign w_addr  = w_addr_q;
    assign b_addr  = b_addr_q;
    assign y_valid = (state_q == EMIT);
    assign y_idx   = y_valid ? n_q : '0;
    assign y_data  = (!y_valid || (RELU && sum_q < 0)) ? '0 : sum_q;
endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Bench for fc_layer_scheduler: four parameter sets side by side, directed and
// random layers checked against a plain arithmetic model of the layer.
module tb_fc_layer_scheduler;
    localparam int NCFG = 4;

    function automatic int il(input int g);
        case (g) 0: return 3; 1: return 3; 2: return 1; default: return 2; endcase
    endfunction
    function automatic int ol(input int g);
        case (g) 0: return 2; 1: return 2; 2: return 3; default: return 2; endcase
    endfunction
    function automatic int rl(input int g);
        return (g == 0) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    logic [NCFG-1:0] start;
    always #5 clk = ~clk;

    logic signed [7:0]  x_mem [NCFG][256];
    logic signed [7:0]  w_mem [NCFG][256];
    logic signed [31:0] b_mem [NCFG][256];

    wire [NCFG-1:0]    busy_a, done_a, yv_a, vin_a, sop_a, eop_a, rv_a;
    wire signed [31:0] yd_a [NCFG];
    wire [7:0]         yi_a [NCFG], xa_a [NCFG], wa_a [NCFG], ba_a [NCFG];
    wire signed [7:0]  da_a [NCFG], db_a [NCFG];

    int nvec, nerr;
    int exp_y [16];

    for (genvar g = 0; g < NCFG; g++) begin : gd
        localparam int IN_L  = il(g);
        localparam int OUT_L = ol(g);
        localparam int XA = (IN_L > 1) ? $clog2(IN_L) : 1;
        localparam int WA = (IN_L * OUT_L > 1) ? $clog2(IN_L * OUT_L) : 1;
        localparam int OA = (OUT_L > 1) ? $clog2(OUT_L) : 1;
        logic [XA-1:0] xa;
        logic [WA-1:0] wa;
        logic [OA-1:0] ba, yi;
        logic signed [7:0]  xd, wd;
        logic signed [31:0] bd, yd;
        logic bsy, dn, yv;

        fc_layer_scheduler #(.IN_LEN(IN_L), .OUT_LEN(OUT_L), .RELU(1'(rl(g)))) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(bsy), .done(dn),
            .x_addr(xa), .x_data(xd), .w_addr(wa), .w_data(wd),
            .b_addr(ba), .b_data(bd), .y_valid(yv), .y_idx(yi), .y_data(yd)
        );

        always @(posedge clk) begin
            xd <= x_mem[g][8'(xa)];
            wd <= w_mem[g][8'(wa)];
            bd <= b_mem[g][8'(ba)];
        end

        assign busy_a[g] = bsy;
        assign done_a[g] = dn;
        assign yv_a[g]   = yv;
        assign yd_a[g]   = yd;
        assign yi_a[g]   = 8'(yi);
        assign xa_a[g]   = 8'(xa);
        assign wa_a[g]   = 8'(wa);
        assign ba_a[g]   = 8'(ba);
        assign vin_a[g]  = u_dut.dp_valid_q;
        assign sop_a[g]  = u_dut.dp_sop_q;
        assign eop_a[g]  = u_dut.dp_eop_q;
        assign rv_a[g]   = u_dut.dp_res_valid;
        assign da_a[g]   = u_dut.dp_a;
        assign db_a[g]   = u_dut.dp_b;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_);
        nvec++;
        assert (obs === exp_) else begin
            nerr++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp_);
        end
    endtask

    task automatic model(input int g);
        int s;
        for (int n = 0; n < ol(g); n++) begin
            s = int'(b_mem[g][n]);
            for (int k = 0; k < il(g); k++)
                s += int'(x_mem[g][k]) * int'(w_mem[g][n * il(g) + k]);
            exp_y[n] = (rl(g) != 0 && s < 0) ? 0 : s;
        end
    endtask

    // Entered at a negedge; leaves at the negedge of the IDLE cycle after done.
    task automatic run(input int g, input bit poke);
        int e, cyc, ny, kk, nn;
        bit fin, rv_prev;
        model(g);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        chk("busy_up", 32'(busy_a[g]), 1);
        e = 0; ny = 0; cyc = 0; fin = 1'b0; rv_prev = 1'b0;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start[g] = poke && (cyc == 2);
            if (vin_a[g]) begin
                kk = e % il(g);
                nn = e / il(g);
                if (e == 0) chk("first_valid_latency", cyc, 1);
                chk("sop", 32'(sop_a[g]), 32'(kk == 0));
                chk("eop", 32'(eop_a[g]), 32'(kk == il(g) - 1));
                chk("x_operand", da_a[g], x_mem[g][kk]);
                chk("w_operand", db_a[g], w_mem[g][nn * il(g) + kk]);
                e++;
            end
            if (rv_a[g]) chk("result_valid_in_wait", 32'(e > 0 && e % il(g) == 0 && !vin_a[g]), 1);
            if (yv_a[g]) begin
                chk("y_after_result", 32'(rv_prev), 1);
                chk("y_idx", 32'(yi_a[g]), ny);
                chk("y_data", yd_a[g], exp_y[ny % 16]);
                ny++;
            end
            if (done_a[g]) begin
                chk("results_per_run", ny, ol(g));
                chk("elems_per_run", e, il(g) * ol(g));
                fin = 1'b1;
            end
            rv_prev = rv_a[g];
        end
        start[g] = 1'b0;
        chk("done_seen", 32'(fin), 1);
        @(negedge clk);
        chk("busy_down", 32'(busy_a[g]), 0);
    endtask

    task automatic chk_zero(input int g);
        chk("rst_busy", 32'(busy_a[g]), 0);
        chk("rst_done", 32'(done_a[g]), 0);
        chk("rst_y_valid", 32'(yv_a[g]), 0);
        chk("rst_y_data", yd_a[g], 0);
        chk("rst_y_idx", 32'(yi_a[g]), 0);
        chk("rst_x_addr", 32'(xa_a[g]), 0);
        chk("rst_w_addr", 32'(wa_a[g]), 0);
        chk("rst_b_addr", 32'(ba_a[g]), 0);
        chk("rst_dp_valid", 32'(vin_a[g]), 0);
        chk("rst_dp_sop", 32'(sop_a[g]), 0);
        chk("rst_dp_eop", 32'(eop_a[g]), 0);
        chk("rst_dp_a", da_a[g], 0);
        chk("rst_dp_b", db_a[g], 0);
        chk("rst_result_valid", 32'(rv_a[g]), 0);
    endtask

    task automatic reset_mid(input int g);
        int cyc;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        cyc = 0;
        while (!yv_a[g] && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_neuron1", 32'(yv_a[g]), 1);
        // two cycles past EMIT lands inside the neuron-1 stream
        @(negedge clk);
        @(negedge clk);
        chk("mid_stream_busy", 32'(busy_a[g]), 1);
        rst_n = 1'b0;
        #1;
        chk_zero(g);
        @(negedge clk);
        rst_n = 1'b1;
        run(g, 1'b0);
    endtask

    task automatic fill_random(input int g);
        for (int i = 0; i < il(g); i++) x_mem[g][i] = 8'($urandom);
        for (int i = 0; i < il(g) * ol(g); i++) w_mem[g][i] = 8'($urandom);
        for (int i = 0; i < ol(g); i++) b_mem[g][i] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        start = '0;
        for (int g = 0; g < NCFG; g++)
            for (int i = 0; i < 256; i++) begin
                x_mem[g][i] = '0; w_mem[g][i] = '0; b_mem[g][i] = '0;
            end
        for (int g = 0; g < 2; g++) begin
            x_mem[g][0] = 8'sd2;  x_mem[g][1] = -8'sd3; x_mem[g][2] = 8'sd4;
            w_mem[g][0] = 8'sd5;  w_mem[g][1] = 8'sd2;  w_mem[g][2] = 8'sd1;
            w_mem[g][3] = -8'sd1; w_mem[g][4] = -8'sd1; w_mem[g][5] = -8'sd1;
            b_mem[g][0] = 32'sd1; b_mem[g][1] = 32'sd0;
        end
        x_mem[2][0] = -8'sd7;
        w_mem[2][0] = 8'sd3;  w_mem[2][1] = 8'sd5; w_mem[2][2] = -8'sd2;
        b_mem[2][0] = 32'sd0; b_mem[2][1] = 32'sd10; b_mem[2][2] = -32'sd4;
        x_mem[3][0] = 8'sd127; x_mem[3][1] = 8'sd127;
        w_mem[3][0] = 8'sd127; w_mem[3][1] = 8'sd127;
        w_mem[3][2] = -8'sd128; w_mem[3][3] = -8'sd128;
        b_mem[3][0] = 32'h7FFF_FFFF; b_mem[3][1] = 32'sd0;

        repeat (3) @(negedge clk);
        for (int g = 0; g < NCFG; g++) chk_zero(g);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 1'b0);      // ReLU run: 9, 0
        run(1, 1'b0);      // raw run: 9, -3
        run(2, 1'b0);      // single-element rows: -21 first
        run(3, 1'b0);      // bias wraps past 0x7FFFFFFF
        run(0, 1'b1);      // stray start while busy
        run(0, 1'b0);      // accepted in the IDLE cycle right after done
        reset_mid(0);

        for (int r = 0; r < 6; r++)
            for (int g = 0; g < NCFG; g++) begin
                fill_random(g);
                run(g, 1'(r % 2));
            end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fc_layer_scheduler.md
# fc_layer_scheduler

Sequencer for one fully connected layer. It streams an input-activation vector and each weight row from synchronous memories into an instantiated `vector_dot_product`, framing each row with `sop`/`eop`. It then adds the per-neuron bias, optionally applies ReLU, and emits one 32-bit result per output neuron. It sits between the layer buffers (activation RAM, weight/bias ROMs) and the next layer's input buffer.

## Interface
Parameters:
- `IN_LEN`, 784: elements per input vector. Must be ≥ 1.
- `OUT_LEN`, 10: number of output neurons. Must be ≥ 1.
- `RELU`, 1: 1 clamps negative results to 0; 0 passes the raw sum.
- Localparams:
  - `X_AW = max(1, clog2(IN_LEN))`
  - `W_AW = max(1, clog2(IN_LEN*OUT_LEN))`
  - `O_AW = max(1, clog2(OUT_LEN))`

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to run the layer. Ignored while `busy`=1.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse after the last neuron's `y_valid`.
- `x_addr` out X_AW: activation RAM address.
- `x_data` in 8 signed: activation data, 1-cycle read latency.
- `w_addr` out W_AW: weight ROM address, row-major (`n*IN_LEN + k`).
- `w_data` in 8 signed: weight data, 1-cycle read latency.
- `b_addr` out O_AW: bias ROM address.
- `b_data` in 32 signed: bias data, 1-cycle read latency.
- `y_valid` out 1: one-cycle pulse per neuron.
- `y_idx` out O_AW: neuron index of `y_data`.
- `y_data` out 32 signed: neuron result.

## Operation
States: IDLE, STREAM, WAIT_RES, EMIT, DONE.
- **IDLE**
  - `start`=1 clears `n`, `k`, `w_addr` and `b_addr` to 0, then moves to STREAM.
- **STREAM**
  - Each cycle issues `x_addr=k` and `w_addr` (a running counter incremented by 1; no multiplier).
  - On the first cycle of each neuron, also issues `b_addr=n`.
  - One cycle after each issue, drives the dot product: `valid_in=1`, `data_a=x_data`, `data_b=w_data`, `sop=(k_d==0)`, `eop=(k_d==IN_LEN-1)`, where `k_d` is `k` delayed one cycle.
  - `b_data` is captured one cycle after `b_addr` is issued.
  - After the address with `k=IN_LEN-1`, moves to WAIT_RES.
- **WAIT_RES**
  - Holds all addresses. The last element (with `eop`) drives the dot product during the first cycle of this state.
  - Waits for `result_valid`. No fixed dot-product latency is assumed.
  - Captures `sum = result + bias` with 32-bit two's-complement wrap, then moves to EMIT.
- **EMIT**
  - `y_valid=1`, `y_idx=n`, `y_data = (RELU && sum<0) ? 0 : sum`.
  - If `n==OUT_LEN-1`, moves to DONE. Otherwise increments `n`, clears `k`, and returns to STREAM. `w_addr` continues from the previous value.
- **DONE**
  - `done=1` for one cycle, then moves to IDLE.

Boundary conditions:
- `IN_LEN=1`: `sop` and `eop` are asserted in the same cycle.
- `start` while `busy`: ignored, with no side effects.
- `rst_n` low mid-run: immediate return to IDLE. All counters clear and the partial layer is discarded. The dot product is also reset.
- `result_valid` in any state other than WAIT_RES: ignored. This is a protocol error and the bench flags it.

## Timing
- Reset values:
  - All outputs are 0, including the internal dot-product drive signals.
  - State is IDLE.
- `start` sampled at edge T. STREAM begins at T+1. First `valid_in`/`sop` at T+2.
- Per-neuron stream: IN_LEN consecutive `valid_in` cycles with no bubbles.
- Per neuron: IN_LEN + 1 + L_DP + 1 cycles, where L_DP is the dot-product latency from `eop` to `result_valid`.
- `y_valid` occurs one cycle after `result_valid`.
- `done` occurs one cycle after the final `y_valid`.
- `busy` falls the cycle after `done`. A new `start` is accepted in that IDLE cycle.

## Structure
- Shared package `fc_pkg`:
  - `DATA_W=8`
  - `ACC_W=32`
  - the state encoding `fc_state_t` (IDLE, STREAM, WAIT_RES, EMIT, DONE)
- One natural sub-module: an instance of `vector_dot_product`.
- All sequencing, address counters and the bias/ReLU stage live in this module.

## Test plan
1. **Two-neuron ReLU run.** `IN_LEN=3`, `OUT_LEN=2`, `RELU=1`, x=[2,-3,4], w0=[5,2,1], w1=[-1,-1,-1], b=[1,0]. Expect `y(0)=9`, `y(1)=0`, then one `done`.
2. **Same run, `RELU=0`.** Expect `y(1)=-3`.
3. **`IN_LEN=1`.** x=[-7], w=[3], b=[0], `RELU=0`. Expect `sop`/`eop` in the same cycle and `y=-21`.
4. **Wrap-around.** `IN_LEN=2`, x=[127,127], w=[127,127], b=[0x7FFFFFFF]. Expect `y_data = 32258 + 0x7FFFFFFF` wrapped to 32 bits, `RELU=0`.
5. **Busy `start` and back-to-back runs.** Pulse `start` mid-run: expect no effect on address sequences or results. Pulse `start` in the IDLE cycle after `done`: expect an identical second result set.
6. **Reset mid-run.** Assert `rst_n` during STREAM of neuron 1. Expect all outputs 0 and IDLE immediately. A fresh `start` must then reproduce scenario 1 results.
